// File: rtl/plru_cam.sv
// ----------------------------------------------------------------------------
// plru_cam : multi-port CAM with self-managed allocation and tree PLRU victims
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module plru_cam #(
  parameter  int NUM_ENTRIES      = 4,
  parameter  int KEY_WIDTH        = 32,
  parameter  int NUM_LOOKUP_PORTS = 2,
  localparam int INDEX_WIDTH      = $clog2(NUM_ENTRIES)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_LOOKUP_PORTS-1:0]                    lookup_en,
  input  logic [NUM_LOOKUP_PORTS-1:0][KEY_WIDTH-1:0]     lookup_key,
  output logic [NUM_LOOKUP_PORTS-1:0]                    lookup_hit,
  output logic [NUM_LOOKUP_PORTS-1:0][INDEX_WIDTH-1:0]   lookup_idx,
  input  logic                                           update_en,
  input  logic [INDEX_WIDTH-1:0]                         update_idx,
  input  logic [KEY_WIDTH-1:0]                           update_key,
  input  logic                                           update_valid,
  input  logic                                           alloc_en,
  input  logic [KEY_WIDTH-1:0]                           alloc_key,
  output logic                                           alloc_ack,
  output logic [INDEX_WIDTH-1:0]                         alloc_idx,
  output logic                                           alloc_hit,
  output logic                                           alloc_evict,
  output logic [KEY_WIDTH-1:0]                           alloc_evict_key,
  input  logic                                           flush
);

  localparam int LEVELS = INDEX_WIDTH;
  localparam int NODES  = NUM_ENTRIES - 1;

  // Heap-ordered tree: children of node n are 2n+1 (lower) and 2n+2 (upper).
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0]       tree,
                                                  input logic [INDEX_WIDTH-1:0] idx);
    logic [NODES-1:0] t;
    int               node;
    logic             dir;
    t    = tree;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      dir     = idx[LEVELS-1-l];
      t[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return t;
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] plru_victim(input logic [NODES-1:0] tree);
    int node;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      node = 2 * node + 1 + int'(tree[node]);
    end
    return INDEX_WIDTH'(node - NODES);
  endfunction

  logic [KEY_WIDTH-1:0]   key_q [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]   key_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NODES-1:0]       plru_q, plru_d;

  logic [NUM_LOOKUP_PORTS-1:0]                  lookup_hit_q, lookup_hit_d;
  logic [NUM_LOOKUP_PORTS-1:0][INDEX_WIDTH-1:0] lookup_idx_q, lookup_idx_d;
  logic                   alloc_ack_q, alloc_ack_d;
  logic [INDEX_WIDTH-1:0] alloc_idx_q, alloc_idx_d;
  logic                   alloc_hit_q, alloc_hit_d;
  logic                   alloc_evict_q, alloc_evict_d;
  logic [KEY_WIDTH-1:0]   alloc_evict_key_q, alloc_evict_key_d;

  logic [NUM_ENTRIES-1:0] lk_match [NUM_LOOKUP_PORTS];
  logic                   alloc_match;
  logic [INDEX_WIDTH-1:0] alloc_match_idx;
  logic                   free_found;
  logic [INDEX_WIDTH-1:0] free_idx;
  logic [INDEX_WIDTH-1:0] victim;
  logic                   wr_touch;
  logic [INDEX_WIDTH-1:0] wr_touch_idx;

  always_comb begin
    key_d             = key_q;
    valid_d           = valid_q;
    plru_d            = plru_q;
    lookup_hit_d      = '0;
    lookup_idx_d      = '0;
    alloc_ack_d       = 1'b0;
    alloc_idx_d       = '0;
    alloc_hit_d       = 1'b0;
    alloc_evict_d     = 1'b0;
    alloc_evict_key_d = '0;
    alloc_match       = 1'b0;
    alloc_match_idx   = '0;
    free_found        = 1'b0;
    free_idx          = '0;
    victim            = '0;
    wr_touch          = 1'b0;
    wr_touch_idx      = '0;
    for (int p = 0; p < NUM_LOOKUP_PORTS; p++) lk_match[p] = '0;

    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (valid_q[e] && key_q[e] == alloc_key) begin
        alloc_match     = 1'b1;
        alloc_match_idx = INDEX_WIDTH'(e);
      end
    end
    // Descending scan so the lowest-index free entry wins.
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (!valid_q[e]) begin
        free_found = 1'b1;
        free_idx   = INDEX_WIDTH'(e);
      end
    end

    if (flush) begin
      valid_d = '0;
    end else if (update_en) begin
      key_d[update_idx]   = update_key;
      valid_d[update_idx] = update_valid;
      wr_touch            = update_valid;
      wr_touch_idx        = update_idx;
    end else if (alloc_en) begin
      alloc_ack_d = 1'b1;
      if (alloc_match) begin
        alloc_hit_d = 1'b1;
        alloc_idx_d = alloc_match_idx;
      end else begin
        victim            = free_found ? free_idx : plru_victim(plru_q);
        alloc_idx_d       = victim;
        alloc_evict_d     = valid_q[victim];
        alloc_evict_key_d = valid_q[victim] ? key_q[victim] : '0;
        key_d[victim]     = alloc_key;
        valid_d[victim]   = 1'b1;
      end
      wr_touch     = 1'b1;
      wr_touch_idx = alloc_idx_d;
    end

    // Lookups see this edge's writes; their touches precede the write touch.
    for (int p = 0; p < NUM_LOOKUP_PORTS; p++) begin
      if (lookup_en[p] && !flush) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (valid_d[e] && key_d[e] == lookup_key[p]) begin
            lk_match[p][e]  = 1'b1;
            lookup_hit_d[p] = 1'b1;
            lookup_idx_d[p] = lookup_idx_d[p] | INDEX_WIDTH'(e);
          end
        end
        if (lookup_hit_d[p]) plru_d = plru_touch(plru_d, lookup_idx_d[p]);
      end
    end
    if (wr_touch) plru_d = plru_touch(plru_d, wr_touch_idx);
    if (flush)    plru_d = '0;
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q           <= '0;
      plru_q            <= '0;
      lookup_hit_q      <= '0;
      lookup_idx_q      <= '0;
      alloc_ack_q       <= 1'b0;
      alloc_idx_q       <= '0;
      alloc_hit_q       <= 1'b0;
      alloc_evict_q     <= 1'b0;
      alloc_evict_key_q <= '0;
    end else begin
      valid_q           <= valid_d;
      plru_q            <= plru_d;
      lookup_hit_q      <= lookup_hit_d;
      lookup_idx_q      <= lookup_idx_d;
      alloc_ack_q       <= alloc_ack_d;
      alloc_idx_q       <= alloc_idx_d;
      alloc_hit_q       <= alloc_hit_d;
      alloc_evict_q     <= alloc_evict_d;
      alloc_evict_key_q <= alloc_evict_key_d;
    end
  end

  assign lookup_hit      = lookup_hit_q;
  assign lookup_idx      = lookup_idx_q;
  assign alloc_ack       = alloc_ack_q;
  assign alloc_idx       = alloc_idx_q;
  assign alloc_hit       = alloc_hit_q;
  assign alloc_evict     = alloc_evict_q;
  assign alloc_evict_key = alloc_evict_key_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_LOOKUP_PORTS; p++) begin
        assert ($countones(lk_match[p]) <= 1)
          else $error("plru_cam: port %0d matched several valid entries", p);
      end
    end
  end
`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset && !flush && update_en && update_valid) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (INDEX_WIDTH'(e) != update_idx && valid_q[e] && key_q[e] == update_key) begin
          $display("plru_cam: duplicate key %0h at slots %0d and %0d", update_key, e, update_idx);
          $finish;
        end
      end
    end
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_plru_cam.sv
// ----------------------------------------------------------------------------
// tb_plru_cam : directed self-checking bench for plru_cam (4 entries, 8b keys)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_plru_cam;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      lookup_en;
  logic [1:0][7:0] lookup_key;
  logic [1:0]      lookup_hit;
  logic [1:0][1:0] lookup_idx;
  logic            update_en;
  logic [1:0]      update_idx;
  logic [7:0]      update_key;
  logic            update_valid;
  logic            alloc_en;
  logic [7:0]      alloc_key;
  logic            alloc_ack;
  logic [1:0]      alloc_idx;
  logic            alloc_hit;
  logic            alloc_evict;
  logic [7:0]      alloc_evict_key;
  logic            flush;

  int vectors     = 0;
  int miscompares = 0;

  plru_cam #(
    .NUM_ENTRIES      (4),
    .KEY_WIDTH        (8),
    .NUM_LOOKUP_PORTS (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_en       (lookup_en),
    .lookup_key      (lookup_key),
    .lookup_hit      (lookup_hit),
    .lookup_idx      (lookup_idx),
    .update_en       (update_en),
    .update_idx      (update_idx),
    .update_key      (update_key),
    .update_valid    (update_valid),
    .alloc_en        (alloc_en),
    .alloc_key       (alloc_key),
    .alloc_ack       (alloc_ack),
    .alloc_idx       (alloc_idx),
    .alloc_hit       (alloc_hit),
    .alloc_evict     (alloc_evict),
    .alloc_evict_key (alloc_evict_key),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_en    = 2'b00;
    lookup_key   = '0;
    update_en    = 1'b0;
    update_idx   = 2'd0;
    update_key   = 8'h00;
    update_valid = 1'b0;
    alloc_en     = 1'b0;
    alloc_key    = 8'h00;
    flush        = 1'b0;
  endtask

  task automatic do_alloc(input logic [7:0] key);
    idle();
    alloc_en  = 1'b1;
    alloc_key = key;
  endtask

  task automatic chk_alloc(input string tag, input logic ack, input logic [1:0] idx,
                           input logic hit, input logic ev, input logic [7:0] evk);
    chk({tag, "_ack"},   32'(alloc_ack),       32'(ack));
    chk({tag, "_idx"},   32'(alloc_idx),       32'(idx));
    chk({tag, "_hit"},   32'(alloc_hit),       32'(hit));
    chk({tag, "_evict"}, 32'(alloc_evict),     32'(ev));
    chk({tag, "_evkey"}, 32'(alloc_evict_key), 32'(evk));
  endtask

  task automatic chk_lookup(input string tag, input logic [1:0] hit,
                            input logic [1:0] idx0, input logic [1:0] idx1);
    chk({tag, "_hit"},  32'(lookup_hit),    32'(hit));
    chk({tag, "_idx0"}, 32'(lookup_idx[0]), 32'(idx0));
    chk({tag, "_idx1"}, 32'(lookup_idx[1]), 32'(idx1));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk_lookup("rst", 2'b00, 2'd0, 2'd0);
    chk_alloc("rst", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;

    // Fill empty table: lowest free entry each time.
    do_alloc(8'h10); tick(); chk_alloc("fill0", 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    do_alloc(8'h20); tick(); chk_alloc("fill1", 1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
    do_alloc(8'h30); tick(); chk_alloc("fill2", 1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
    do_alloc(8'h40);
    lookup_en     = 2'b10;
    lookup_key[1] = 8'h40;   // same-edge alloc is visible to lookup
    tick();
    chk_alloc("fill3", 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
    chk_lookup("lk_fill3", 2'b10, 2'd0, 2'd3);

    // Two-port lookup, hit and miss.  Touch 1 -> root=1, n1=0, n2=0.
    idle();
    lookup_en  = 2'b11;
    lookup_key[0] = 8'h20;
    lookup_key[1] = 8'h55;
    tick();
    chk_lookup("lk2", 2'b01, 2'd1, 2'd0);

    // Touch 0 -> root=1, n1=1, n2=0: victim is entry 2.
    idle();
    lookup_en     = 2'b01;
    lookup_key[0] = 8'h10;
    tick();
    chk_lookup("lk10", 2'b01, 2'd0, 2'd0);

    do_alloc(8'h50); tick();
    chk_alloc("plru_vict", 1'b1, 2'd2, 1'b0, 1'b1, 8'h30);
    chk_lookup("lk_off", 2'b00, 2'd0, 2'd0);

    // Existing key: hit, nothing written.  Touch 3 -> root=0, n1=1, n2=0.
    do_alloc(8'h40); tick();
    chk_alloc("exist", 1'b1, 2'd3, 1'b1, 1'b0, 8'h00);

    // Same-cycle update with dropped alloc.  Touch 1 -> root=1, n1=0, n2=0.
    idle();
    update_en     = 1'b1;
    update_idx    = 2'd1;
    update_key    = 8'h66;
    update_valid  = 1'b1;
    alloc_en      = 1'b1;
    alloc_key     = 8'h77;
    lookup_en     = 2'b11;
    lookup_key[0] = 8'h66;
    lookup_key[1] = 8'h20;
    tick();
    chk_lookup("upd_same", 2'b01, 2'd1, 2'd0);
    chk_alloc("upd_drop", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);

    // Table 10,66,50,40; victim entry 2.  Touch 2 -> root=0, n1=0, n2=1.
    do_alloc(8'h77); tick();
    chk_alloc("re_issue", 1'b1, 2'd2, 1'b0, 1'b1, 8'h50);

    // Invalidate entry 3 while looking it up: miss.
    idle();
    update_en     = 1'b1;
    update_idx    = 2'd3;
    update_key    = 8'h40;
    update_valid  = 1'b0;
    lookup_en     = 2'b01;
    lookup_key[0] = 8'h40;
    tick();
    chk_lookup("inval", 2'b00, 2'd0, 2'd0);

    // Free entry 3 preferred over PLRU victim 0.
    do_alloc(8'h88);
    lookup_en     = 2'b10;
    lookup_key[1] = 8'h88;
    tick();
    chk_alloc("free_pref", 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
    chk_lookup("lk_free", 2'b10, 2'd0, 2'd3);

    // Flush drops the alloc and misses every lookup.
    do_alloc(8'h99);
    flush         = 1'b1;
    lookup_en     = 2'b11;
    lookup_key[0] = 8'h10;
    lookup_key[1] = 8'h66;
    tick();
    chk_alloc("flush", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    chk_lookup("lk_flush", 2'b00, 2'd0, 2'd0);

    idle();
    lookup_en     = 2'b11;
    lookup_key[0] = 8'h77;
    lookup_key[1] = 8'h88;
    tick();
    chk_lookup("post_flush", 2'b00, 2'd0, 2'd0);

    do_alloc(8'hAA); tick();
    chk_alloc("post_flush_alloc", 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-alloc.
    do_alloc(8'hBB);
    lookup_en     = 2'b11;
    lookup_key[0] = 8'hAA;
    lookup_key[1] = 8'hAA;
    #2;
    reset = 1'b1;
    #1;
    chk_alloc("rst_async", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    tick();
    chk_alloc("rst_mid", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    chk_lookup("rst_mid", 2'b00, 2'd0, 2'd0);
    idle();
    reset = 1'b0;
    lookup_en     = 2'b01;
    lookup_key[0] = 8'hAA;
    tick();
    chk_lookup("post_rst", 2'b00, 2'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/plru_cam.md
# plru_cam

Multi-port content-addressable memory with self-managed allocation and tree pseudo-LRU replacement, the next generation of the core's single-port CAM. It serves TLBs and miss-tracking tables that need several lookups per cycle and want the CAM, not the client, to choose victims. Lookups are registered: results appear one cycle after the request and reflect that edge's writes. Allocation never creates duplicate keys.

## Interface
- NUM_ENTRIES, 4: entry count; power of two, ≥2.
- KEY_WIDTH, 32: key width.
- NUM_LOOKUP_PORTS, 2: independent lookup ports, ≥1.
- INDEX_WIDTH, $clog2(NUM_ENTRIES): derived; not overridden.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- lookup_en  in  [NUM_LOOKUP_PORTS]  per-port lookup request.
- lookup_key  in  [NUM_LOOKUP_PORTS][KEY_WIDTH]  per-port key.
- lookup_hit  out  [NUM_LOOKUP_PORTS]  registered hit.
- lookup_idx  out  [NUM_LOOKUP_PORTS][INDEX_WIDTH]  registered matching index; 0 on miss.
- update_en  in  1  direct write to update_idx.
- update_idx  in  INDEX_WIDTH  target entry.
- update_key  in  KEY_WIDTH  key written.
- update_valid  in  1  valid bit written (0 = invalidate).
- alloc_en  in  1  allocate alloc_key.
- alloc_key  in  KEY_WIDTH  key to allocate.
- alloc_ack  out  1  registered; alloc accepted last cycle.
- alloc_idx  out  INDEX_WIDTH  entry holding alloc_key.
- alloc_hit  out  1  key was already present; nothing written.
- alloc_evict  out  1  a valid entry was displaced.
- alloc_evict_key  out  KEY_WIDTH  displaced key.
- flush  in  1  synchronous invalidate-all.

## Operation
- State: key array (not reset), valid bits, NUM_ENTRIES-1 PLRU tree bits.
- Per-edge priority: flush > update_en > alloc_en. Flush clears all valid and PLRU bits. Alloc is dropped (alloc_ack=0 next cycle) when flush or update_en is high; the requester re-issues.
- Update: key[update_idx]<=update_key, valid<=update_valid; update_valid=1 touches update_idx in PLRU.
- Alloc: if a valid entry matches alloc_key, alloc_hit=1, alloc_idx=that entry, no write, entry touched. Otherwise the victim is the lowest-index invalid entry, else the PLRU victim. Write key, set valid, touch. alloc_evict=1 and alloc_evict_key=old key only if the victim was valid.
- PLRU: binary tree, root = node 0. Node bit 0 points to the lower half, 1 to the upper half. Victim walk follows the bits. Touch sets every node on the path to point away from the touched entry.
- Touch order within a cycle: lookup hits in ascending port order, then update/alloc. A later touch overrides an earlier one on shared nodes.
- Lookup compares against the post-write state of the same edge: same-cycle update/alloc of key K → hit. Same-cycle invalidate or overwrite of the matching entry → miss. Lookups during flush miss.
- Lookup hits touch PLRU. When lookup_en=0, next-cycle lookup_hit=0 and lookup_idx=0.
- More than one matching valid entry: assertion failure. Under SIMULATION, an update_en that would create a duplicate valid key at another index prints both slots and calls $finish.

## Timing
- Lookup latency 1 cycle; alloc result 1 cycle; fully pipelined, one lookup per port and one alloc per cycle.
- Writes visible to lookups and allocs issued the same cycle.
- Reset (any time, including mid-alloc): all valid=0, PLRU=0, all outputs 0 (lookup_hit, lookup_idx, alloc_ack, alloc_idx, alloc_hit, alloc_evict, alloc_evict_key). In-flight results are discarded.
- Alloc outputs other than alloc_ack are don't-care when alloc_ack=0, but are driven 0.

## Test plan
(NUM_ENTRIES=4, KEY_WIDTH=8, NUM_LOOKUP_PORTS=2)
- Fill: after reset, alloc 0x10, 0x20, 0x30, 0x40 on consecutive cycles → alloc_ack=1 each, alloc_idx=0,1,2,3, alloc_evict=0; PLRU ends root=0, node2=0.
- Lookup: port0 0x20, port1 0x55 same cycle → next cycle hit={0,1} idx0=1, hit1=0, idx1=0.
- PLRU victim: after fill, lookup 0x10 hits entry 0; then alloc 0x50 → alloc_idx=2, alloc_evict=1, alloc_evict_key=0x30.
- Existing key: alloc 0x40 → alloc_idx=3, alloc_hit=1, alloc_evict=0; table unchanged.
- Same-cycle write: update_en idx1 key 0x66 valid=1, port0 lookup 0x66, port1 lookup 0x20 → next cycle port0 hit idx1, port1 miss.
- Flush and reset: flush with alloc_en → alloc_ack=0; next lookups of any filled key miss. Assert reset mid-alloc → all outputs 0 the following cycle.
